// File: rtl/i3c_ahb_mgr.sv
// ---------------------------------------------------------------------------
// i3c_ahb_mgr -- AHB-Lite manager bridge
//
// Turns a CSR-style client request/ack handshake into single AHB-Lite
// transfers (one outstanding transfer, no bursts). Used by the I3C core to
// push and pull queue/FIFO data to and from system memory.
//
// Optional feature: define I3C_AHB_MGR_ALIGN_CHECK_EN to reject requests
// whose byte address is not word aligned. A rejected request issues no AHB
// transfer and is answered one cycle later with an error ack.
//
// Ports:
//   hclk_i, hreset_i          clock, synchronous active-high reset
//   req_i, req_is_wr_i,       client request (valid, direction, byte
//   req_addr_i, req_wdata_i   address, write word)
//   req_stall_o               request not accepted this cycle
//   rd_ack_o, rd_err_o,       read completion pulse, error flag and data
//   rd_data_o                 (data held until the next read ack)
//   wr_ack_o, wr_err_o        write completion pulse and error flag
//   haddr_o .. hwdata_o       AHB-Lite manager outputs
//   hrdata_i, hready_i,       AHB-Lite subordinate responses
//   hresp_i
// ---------------------------------------------------------------------------
module i3c_ahb_mgr #(
    parameter int AHB_ADDR_WIDTH    = 32,
    parameter int AHB_DATA_WIDTH    = 64,
    parameter int CLIENT_DATA_WIDTH = 32
) (
    input  logic                         hclk_i,
    input  logic                         hreset_i,

    input  logic                         req_i,
    input  logic                         req_is_wr_i,
    input  logic [AHB_ADDR_WIDTH-1:0]    req_addr_i,
    input  logic [CLIENT_DATA_WIDTH-1:0] req_wdata_i,
    output logic                         req_stall_o,

    output logic                         rd_ack_o,
    output logic                         rd_err_o,
    output logic [CLIENT_DATA_WIDTH-1:0] rd_data_o,
    output logic                         wr_ack_o,
    output logic                         wr_err_o,

    output logic [AHB_ADDR_WIDTH-1:0]    haddr_o,
    output logic [2:0]                   hburst_o,
    output logic [3:0]                   hprot_o,
    output logic [2:0]                   hsize_o,
    output logic [1:0]                   htrans_o,
    output logic                         hwrite_o,
    output logic [AHB_DATA_WIDTH-1:0]    hwdata_o,
    input  logic [AHB_DATA_WIDTH-1:0]    hrdata_i,
    input  logic                         hready_i,
    input  logic                         hresp_i
);

    localparam int LANES  = AHB_DATA_WIDTH / CLIENT_DATA_WIDTH;
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_ERR
    } state_t;

    state_t state_reg, state_next;

    // Request captured at acceptance; stays put until the next acceptance,
    // which keeps address/data stable through every wait state.
    logic [AHB_ADDR_WIDTH-1:0]    addr_reg;
    logic                         is_wr_reg;
    logic [CLIENT_DATA_WIDTH-1:0] wdata_reg;
    logic                         capture;

    logic rd_ack_reg, rd_ack_next;
    logic rd_err_reg, rd_err_next;
    logic wr_ack_reg, wr_ack_next;
    logic wr_err_reg, wr_err_next;
    logic [CLIENT_DATA_WIDTH-1:0] rd_data_reg, rd_data_next;

    logic                         misaligned;
    logic [LANE_W-1:0]            lane_sel;
    logic [CLIENT_DATA_WIDTH-1:0] rd_lane [LANES];

    // Split the read bus into client-sized lanes and replicate the write
    // word across every lane so any byte-lane decoder sees the right data.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        assign rd_lane[gi] = hrdata_i[gi*CLIENT_DATA_WIDTH +: CLIENT_DATA_WIDTH];
        assign hwdata_o[gi*CLIENT_DATA_WIDTH +: CLIENT_DATA_WIDTH] = wdata_reg;
    end

    // Word lane within the bus comes from the address bits just above the
    // byte offset; bits above the bus width wrap naturally.
    if (LANES > 1) begin : g_sel
        assign lane_sel = addr_reg[2 +: LANE_W];
    end else begin : g_sel_single
        assign lane_sel = '0;
    end

`ifdef I3C_AHB_MGR_ALIGN_CHECK_EN
    assign misaligned = (req_addr_i[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // State and registered outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge hclk_i) begin
        if (hreset_i) begin
            state_reg   <= S_IDLE;
            addr_reg    <= '0;
            is_wr_reg   <= 1'b0;
            wdata_reg   <= '0;
            rd_ack_reg  <= 1'b0;
            rd_err_reg  <= 1'b0;
            wr_ack_reg  <= 1'b0;
            wr_err_reg  <= 1'b0;
            rd_data_reg <= '0;
        end else begin
            state_reg   <= state_next;
            rd_ack_reg  <= rd_ack_next;
            rd_err_reg  <= rd_err_next;
            wr_ack_reg  <= wr_ack_next;
            wr_err_reg  <= wr_err_next;
            rd_data_reg <= rd_data_next;
            if (capture) begin
                addr_reg  <= req_addr_i;
                is_wr_reg <= req_is_wr_i;
                wdata_reg <= req_wdata_i;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Next state and next registered outputs
    // -----------------------------------------------------------------------
    always_comb begin
        state_next   = state_reg;
        capture      = 1'b0;
        rd_ack_next  = 1'b0;
        rd_err_next  = 1'b0;
        wr_ack_next  = 1'b0;
        wr_err_next  = 1'b0;
        rd_data_next = rd_data_reg;

        case (state_reg)
            S_IDLE: begin
                if (req_i) begin
                    if (misaligned) begin
                        // Rejected without touching the bus.
                        wr_ack_next = req_is_wr_i;
                        wr_err_next = req_is_wr_i;
                        rd_ack_next = !req_is_wr_i;
                        rd_err_next = !req_is_wr_i;
                        if (!req_is_wr_i) begin
                            rd_data_next = '0;
                        end
                    end else begin
                        capture    = 1'b1;
                        state_next = S_ADDR;
                    end
                end
            end

            S_ADDR: begin
                if (hready_i) begin
                    state_next = S_DATA;
                end
            end

            S_DATA: begin
                if (hready_i) begin
                    // hresp with hready is still a completion, just a
                    // failed one.
                    state_next = S_IDLE;
                    if (is_wr_reg) begin
                        wr_ack_next = 1'b1;
                        wr_err_next = hresp_i;
                    end else begin
                        rd_ack_next  = 1'b1;
                        rd_err_next  = hresp_i;
                        rd_data_next = hresp_i ? '0 : rd_lane[lane_sel];
                    end
                end else if (hresp_i) begin
                    // First cycle of the two-cycle error response.
                    state_next = S_ERR;
                end
            end

            S_ERR: begin
                if (hready_i) begin
                    state_next = S_IDLE;
                    if (is_wr_reg) begin
                        wr_ack_next = 1'b1;
                        wr_err_next = 1'b1;
                    end else begin
                        rd_ack_next  = 1'b1;
                        rd_err_next  = 1'b1;
                        rd_data_next = '0;
                    end
                end
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign req_stall_o = !hreset_i && (state_reg != S_IDLE);

    assign rd_ack_o  = rd_ack_reg;
    assign rd_err_o  = rd_err_reg;
    assign rd_data_o = rd_data_reg;
    assign wr_ack_o  = wr_ack_reg;
    assign wr_err_o  = wr_err_reg;

    assign htrans_o = (state_reg == S_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign haddr_o  = addr_reg;
    assign hwrite_o = is_wr_reg;
    assign hburst_o = 3'b000;
    assign hprot_o  = 4'b0011;
    assign hsize_o  = 3'b010;

endmodule

// File: tb/tb_i3c_ahb_mgr.sv
// ---------------------------------------------------------------------------
// tb_i3c_ahb_mgr -- self-checking bench for i3c_ahb_mgr
//
// A transaction-level model predicts, for every transfer, which cycles carry
// NONSEQ, which cycles are stalled and in which cycle the ack appears, from
// the acceptance cycle plus the number of wait states the bench's own
// subordinate inserts. One compare process checks the DUT against that
// prediction on every cycle. Directed transfers add literal expectations.
// ---------------------------------------------------------------------------
module tb_i3c_ahb_mgr;

    localparam int AW    = 32;
    localparam int DW    = 64;
    localparam int CW    = 32;
    localparam int LANES = DW / CW;

    logic          hclk_i = 1'b0;
    logic          hreset_i;
    logic          req_i;
    logic          req_is_wr_i;
    logic [AW-1:0] req_addr_i;
    logic [CW-1:0] req_wdata_i;
    logic          req_stall_o;
    logic          rd_ack_o, rd_err_o, wr_ack_o, wr_err_o;
    logic [CW-1:0] rd_data_o;
    logic [AW-1:0] haddr_o;
    logic [2:0]    hburst_o;
    logic [3:0]    hprot_o;
    logic [2:0]    hsize_o;
    logic [1:0]    htrans_o;
    logic          hwrite_o;
    logic [DW-1:0] hwdata_o;
    logic [DW-1:0] hrdata_i;
    logic          hready_i;
    logic          hresp_i;

    i3c_ahb_mgr #(
        .AHB_ADDR_WIDTH   (AW),
        .AHB_DATA_WIDTH   (DW),
        .CLIENT_DATA_WIDTH(CW)
    ) dut (
        .hclk_i     (hclk_i),
        .hreset_i   (hreset_i),
        .req_i      (req_i),
        .req_is_wr_i(req_is_wr_i),
        .req_addr_i (req_addr_i),
        .req_wdata_i(req_wdata_i),
        .req_stall_o(req_stall_o),
        .rd_ack_o   (rd_ack_o),
        .rd_err_o   (rd_err_o),
        .rd_data_o  (rd_data_o),
        .wr_ack_o   (wr_ack_o),
        .wr_err_o   (wr_err_o),
        .haddr_o    (haddr_o),
        .hburst_o   (hburst_o),
        .hprot_o    (hprot_o),
        .hsize_o    (hsize_o),
        .htrans_o   (htrans_o),
        .hwrite_o   (hwrite_o),
        .hwdata_o   (hwdata_o),
        .hrdata_i   (hrdata_i),
        .hready_i   (hready_i),
        .hresp_i    (hresp_i)
    );

    always #5 hclk_i = ~hclk_i;

    // Cycle k is the period following the k-th rising edge.
    int cyc = 0;
    always @(posedge hclk_i) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // ---------------- transaction-level model ----------------
    bit            m_active  = 1'b0;
    int            m_e       = 0;     // first cycle after acceptance
    int            m_ns_end  = -1;    // last NONSEQ cycle
    int            m_ack     = -1;    // ack cycle
    bit            m_is_wr   = 1'b0;
    bit            m_err     = 1'b0;
    logic [AW-1:0] m_addr    = '0;
    logic [CW-1:0] m_wdata   = '0;
    logic [DW-1:0] m_hrdata  = '0;
    logic [CW-1:0] m_rd_data = '0;

    function automatic logic [CW-1:0] pick_lane(input logic [DW-1:0] bus, input logic [AW-1:0] a);
        int lane;
        lane = int'((a >> 2) % LANES);
        return bus[lane*CW +: CW];
    endfunction

    function automatic logic [DW-1:0] replicate(input logic [CW-1:0] w);
        logic [DW-1:0] r;
        for (int i = 0; i < LANES; i++) r[i*CW +: CW] = w;
        return r;
    endfunction

    // Compare process: every cycle, DUT outputs against the model.
    always @(posedge hclk_i) begin
        #1;
        begin
            int  c;
            bit  ns, busy, ack, data_ph;
            c       = cyc;
            ns      = m_active && c >= m_e && c <= m_ns_end;
            busy    = m_active && c >= m_e && c < m_ack;
            ack     = m_active && c == m_ack;
            data_ph = m_active && c > m_ns_end && c < m_ack && m_ns_end >= m_e;
            if (ack && !m_is_wr) m_rd_data = m_err ? '0 : pick_lane(m_hrdata, m_addr);
            chk("htrans", htrans_o, ns ? 2'b10 : 2'b00);
            chk("stall", req_stall_o, !hreset_i && busy);
            chk("rd_ack", rd_ack_o, ack && !m_is_wr);
            chk("rd_err", rd_err_o, ack && !m_is_wr && m_err);
            chk("wr_ack", wr_ack_o, ack && m_is_wr);
            chk("wr_err", wr_err_o, ack && m_is_wr && m_err);
            chk("rd_data", rd_data_o, m_rd_data);
            if (ns) begin
                chk("haddr", haddr_o, m_addr);
                chk("hwrite", hwrite_o, m_is_wr);
                chk("hburst", hburst_o, 3'b000);
                chk("hprot", hprot_o, 4'b0011);
                chk("hsize", hsize_o, 3'b010);
            end
            if (data_ph && m_is_wr) chk("hwdata", hwdata_o, replicate(m_wdata));
        end
    end

    // Subordinate response for cycle offset r after acceptance.
    // kind: 0 = OK, 1 = two-cycle error, 2 = error with hready high.
    task automatic sched(input int r, input int aw, input int dw, input int kind,
                         output bit rdy, output bit rsp);
        int d;
        rdy = 1'b1;
        rsp = 1'b0;
        if (r < aw) begin
            rdy = 1'b0;
        end else if (r > aw) begin
            d = r - aw - 1;
            if (d < dw) begin
                rdy = 1'b0;
            end else if (d == dw) begin
                if (kind == 1) begin
                    rdy = 1'b0;
                    rsp = 1'b1;
                end else if (kind == 2) begin
                    rsp = 1'b1;
                end
            end else begin
                rsp = 1'b1;
            end
        end
    endtask

    // Must be called at a falling edge of an idle cycle. Returns at the
    // falling edge of the ack cycle (or the cycle after a reset).
    // rst_at >= 0 asserts reset at that cycle offset after acceptance.
    task automatic txn(input bit wr, input logic [AW-1:0] addr, input logic [CW-1:0] wdata,
                       input logic [DW-1:0] rdata, input int aw, input int dw,
                       input int kind, input int rst_at);
        bit rdy, rsp;
        req_i       = 1'b1;
        req_is_wr_i = wr;
        req_addr_i  = addr;
        req_wdata_i = wdata;
        hrdata_i    = rdata;
        m_e      = cyc + 1;
        m_is_wr  = wr;
        m_addr   = addr;
        m_wdata  = wdata;
        m_hrdata = rdata;
        m_err    = (kind != 0);
        m_ns_end = m_e + aw;
        m_ack    = m_e + aw + 2 + dw + ((kind == 1) ? 1 : 0);
`ifdef I3C_AHB_MGR_ALIGN_CHECK_EN
        if (addr[1:0] != 2'b00) begin
            m_ns_end = m_e - 1;
            m_ack    = m_e;
            m_err    = 1'b1;
        end
`endif
        m_active = 1'b1;
        for (int k = m_e; k < m_ack; k++) begin
            @(negedge hclk_i);
            // Stalled requests must be ignored whatever the client drives.
            req_i       = 1'($urandom_range(0, 1));
            req_is_wr_i = 1'($urandom_range(0, 1));
            req_addr_i  = $urandom;
            req_wdata_i = $urandom;
            sched(k - m_e, aw, dw, kind, rdy, rsp);
            hready_i = rdy;
            hresp_i  = rsp;
            if (k - m_e == rst_at) begin
                hreset_i  = 1'b1;
                req_i     = 1'b0;
                m_active  = 1'b0;
                m_rd_data = '0;
                @(negedge hclk_i);
                hreset_i = 1'b0;
                hready_i = 1'b1;
                hresp_i  = 1'b0;
                return;
            end
        end
        @(negedge hclk_i);
        req_i    = 1'b0;
        hready_i = 1'b1;
        hresp_i  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c_ack;
        hreset_i    = 1'b1;
        req_i       = 1'b0;
        req_is_wr_i = 1'b0;
        req_addr_i  = '0;
        req_wdata_i = '0;
        hrdata_i    = '0;
        hready_i    = 1'b1;
        hresp_i     = 1'b0;
        repeat (3) @(negedge hclk_i);
        chk("rst_stall", req_stall_o, 1'b0);
        chk("rst_haddr", haddr_o, '0);
        chk("rst_hwrite", hwrite_o, 1'b0);
        chk("rst_hwdata", hwdata_o, '0);
        chk("rst_rd_data", rd_data_o, '0);
        hreset_i = 1'b0;
        @(negedge hclk_i);

        // Zero-wait write.
        fork
            txn(1'b1, 32'h104, 32'hDEADBEEF, '0, 0, 0, 0, -1);
            begin
                @(posedge hclk_i); #1;
                chk("w0_htrans", htrans_o, 2'b10);
                chk("w0_haddr", haddr_o, 32'h104);
                chk("w0_hwrite", hwrite_o, 1'b1);
                @(posedge hclk_i); #1;
                chk("w0_hwdata", hwdata_o, 64'hDEADBEEF_DEADBEEF);
                @(posedge hclk_i); #1;
                chk("w0_ack", {wr_ack_o, wr_err_o}, 2'b10);
            end
        join

        // Reads with two data-phase wait states, both lanes.
        fork
            txn(1'b0, 32'h108, '0, 64'h11112222_33334444, 0, 2, 0, -1);
            begin
                repeat (5) @(posedge hclk_i); #1;
                chk("r108_ack", {rd_ack_o, rd_err_o}, 2'b10);
                chk("r108_data", rd_data_o, 32'h33334444);
            end
        join
        fork
            txn(1'b0, 32'h10C, '0, 64'h11112222_33334444, 0, 2, 0, -1);
            begin
                repeat (5) @(posedge hclk_i); #1;
                chk("r10c_data", rd_data_o, 32'h11112222);
            end
        join

        // Address-phase stall of three cycles.
        fork
            txn(1'b1, 32'h200, 32'h12345678, '0, 3, 0, 0, -1);
            begin
                for (int i = 0; i < 4; i++) begin
                    @(posedge hclk_i); #1;
                    chk("as_htrans", htrans_o, 2'b10);
                    chk("as_haddr", haddr_o, 32'h200);
                    chk("as_stall", req_stall_o, 1'b1);
                end
                repeat (2) @(posedge hclk_i); #1;
                chk("as_ack", wr_ack_o, 1'b1);
            end
        join

        // Two-cycle error response on a read.
        fork
            txn(1'b0, 32'h300, '0, 64'hAAAAAAAA_BBBBBBBB, 0, 0, 1, -1);
            begin
                repeat (2) @(posedge hclk_i); #1;
                chk("er_htrans1", htrans_o, 2'b00);
                @(posedge hclk_i); #1;
                chk("er_htrans2", htrans_o, 2'b00);
                @(posedge hclk_i); #1;
                chk("er_ack", {rd_ack_o, rd_err_o}, 2'b11);
                chk("er_data", rd_data_o, 32'h0);
            end
        join

        // Back-to-back: next request presented in the ack cycle.
        txn(1'b1, 32'h400, 32'hCAFEF00D, '0, 0, 0, 0, -1);
        c_ack = cyc;
        fork
            txn(1'b0, 32'h404, '0, 64'h55556666_77778888, 0, 0, 0, -1);
            begin
                @(posedge hclk_i); #1;
                chk("b2b_ns_cycle", cyc - c_ack, 1);
                chk("b2b_htrans", htrans_o, 2'b10);
            end
        join

        // Reset during the data phase abandons the transfer.
        txn(1'b1, 32'h500, 32'h0BADF00D, '0, 0, 2, 0, 1);
        chk("rst_mid_htrans", htrans_o, 2'b00);
        chk("rst_mid_ack", {wr_ack_o, rd_ack_o}, 2'b00);
        repeat (2) @(negedge hclk_i);

`ifdef I3C_AHB_MGR_ALIGN_CHECK_EN
        fork
            txn(1'b1, 32'h102, 32'h01020304, '0, 0, 0, 0, -1);
            begin
                @(posedge hclk_i); #1;
                chk("mis_htrans", htrans_o, 2'b00);
                chk("mis_ack", {wr_ack_o, wr_err_o}, 2'b11);
            end
        join
`endif

        // Randomized transfers.
        for (int n = 0; n < 150; n++) begin
            bit            wr;
            logic [AW-1:0] a;
            int            kind, sel;
            wr  = 1'($urandom_range(0, 1));
            a   = $urandom & 32'hFFFF_FFFC;
`ifdef I3C_AHB_MGR_ALIGN_CHECK_EN
            if ($urandom_range(0, 9) == 0) a[1:0] = 2'($urandom_range(1, 3));
`endif
            sel  = $urandom_range(0, 9);
            kind = (sel < 6) ? 0 : ((sel < 8) ? 1 : 2);
            txn(wr, a, $urandom, {$urandom, $urandom},
                $urandom_range(0, 3), $urandom_range(0, 3), kind, -1);
            repeat ($urandom_range(0, 2)) @(negedge hclk_i);
        end

        repeat (3) @(negedge hclk_i);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/i3c_ahb_mgr.md
Name: i3c_ahb_mgr

Overview:
AHB-Lite manager (initiator) bridge. It converts a CSR-style client request/ack interface into single AHB-Lite transfers. The I3C core uses it to issue bus-side accesses, e.g. DMA-style pushes and pulls of queue/FIFO data into system memory. It is the initiator counterpart to the subordinate-side CSR bridge: it has one outstanding transfer at a time and no bursts.

Parameters:
AHB_ADDR_WIDTH, 32, byte address width on both client and AHB sides (10..64)
AHB_DATA_WIDTH, 64, AHB data bus width (32, 64, 128 or 256)
CLIENT_DATA_WIDTH, 32, client data width (fixed word)

Ports:
hclk_i  in  1  clock
hreset_i  in  1  synchronous reset, active-high
req_i  in  1  client request valid; addr/is_wr/wdata valid
req_is_wr_i  in  1  1 = write, 0 = read
req_addr_i  in  AHB_ADDR_WIDTH  byte address
req_wdata_i  in  32  write data
req_stall_o  out  1  high = request not accepted this cycle
rd_ack_o  out  1  one-cycle pulse; read complete, rd_err_o/rd_data_o valid
rd_err_o  out  1  read error
rd_data_o  out  32  read data
wr_ack_o  out  1  one-cycle pulse; write complete
wr_err_o  out  1  write error
haddr_o  out  AHB_ADDR_WIDTH  AHB address
hburst_o  out  3  always 3'b000 (SINGLE)
hprot_o  out  4  always 4'b0011 (non-cacheable, privileged data)
hsize_o  out  3  always 3'b010 (word)
htrans_o  out  2  IDLE 2'b00 / NONSEQ 2'b10
hwrite_o  out  1  transfer direction
hwdata_o  out  AHB_DATA_WIDTH  write data
hrdata_i  in  AHB_DATA_WIDTH  read data
hready_i  in  1  bus ready
hresp_i  in  1  error response

Behaviour:
- Reset values:
  - state IDLE; htrans_o = 00; haddr_o = 0; hwrite_o = 0; hwdata_o = 0.
  - All acks and errs = 0; rd_data_o = 0.
  - req_stall_o = 0 during reset.
- FSM states: IDLE, ADDR, DATA, ERR.
- IDLE:
  - req_stall_o = 0. If req_i is high, capture addr, is_wr and wdata, then go to ADDR.
  - In every other state req_stall_o = 1.
- ADDR:
  - Drive htrans_o = NONSEQ, haddr_o = captured addr, hwrite_o = captured is_wr.
  - Hold all of these while hready_i = 0. On hready_i = 1, go to DATA.
- DATA:
  - htrans_o = IDLE. For a write, hwdata_o carries the captured word replicated on every 32-bit lane; the value is stable for the whole data phase.
  - hready_i = 1, hresp_i = 0: go to IDLE and pulse the matching ack with err = 0.
  - Read capture on that completion: rd_data_o = hrdata_i lane selected by addr[$clog2(AHB_DATA_WIDTH/8)-1:2]; lane 0 when AHB_DATA_WIDTH = 32.
  - hready_i = 0, hresp_i = 1: go to ERR (first cycle of the two-cycle error response).
  - hready_i = 1, hresp_i = 1: treated as an error completion; go to IDLE and pulse ack with err = 1.
- ERR: wait for hready_i = 1, then go to IDLE and pulse ack with err = 1. For reads, rd_data_o = 0.
- Ack and err outputs are registered and asserted for exactly one cycle.
- rd_data_o holds its value until the next read ack.
- Latency: request accepted at edge T → NONSEQ driven in cycle T+1 → zero-wait-state ack in cycle T+3.
  - The block is IDLE in cycle T+3, so a new request can be accepted then.
  - Minimum 3 cycles per transfer; each wait state adds 1.
- Simultaneous events: req_i is ignored while stalled and must be held by the client.
- Reset mid-operation: returns to IDLE at the next edge and abandons the transfer without an ack; the system shares the reset.
- Width rules:
  - Lane index is taken modulo the bus width.
  - addr[1:0] is passed through unchanged on haddr_o unless the optional feature is enabled.

Optional Feature:
Macro I3C_AHB_MGR_ALIGN_CHECK_EN.
- Defined: a request with req_addr_i[1:0] != 0, accepted in IDLE, issues no AHB transfer (htrans_o stays IDLE). The next cycle pulses the matching ack with err = 1 (rd_data_o = 0), and the block stays in IDLE.
- Undefined: no check; the address is forwarded as is.

Test Plan:
- Zero-wait write: req addr 0x104, wdata 0xDEADBEEF, AW = 32, DW = 64.
  - NONSEQ at T+1 with haddr 0x104, hwrite 1.
  - hwdata = 0xDEADBEEF_DEADBEEF at T+2.
  - wr_ack = 1 and wr_err = 0 at T+3.
- Read with 2 wait states: addr 0x108, hrdata = 0x11112222_33334444, hready low for 2 data-phase cycles → rd_ack at T+5 with rd_data = 0x33334444 (lane 0).
  - Repeat with addr 0x10C → rd_data = 0x11112222.
- Address-phase stall: hready_i low for 3 cycles in ADDR → haddr, htrans and hwrite held stable; req_stall_o = 1 throughout; ack 3 cycles later.
- Error response: read with hresp = 1/hready = 0, then hresp = 1/hready = 1 → rd_ack with rd_err = 1, rd_data = 0, htrans IDLE during both cycles.
- Back-to-back: req_i held high with write then read → second NONSEQ exactly at T+4; reset asserted in DATA → IDLE next cycle, no ack, htrans = 00.
- With I3C_AHB_MGR_ALIGN_CHECK_EN: write to 0x102 → no NONSEQ, wr_ack with wr_err = 1 one cycle after acceptance.
